// File: rtl/dma_mc_engine.sv
// dma_mc_engine: multi-channel Avalon-MM master DMA engine.
// Each client channel posts one request at a time (single/block read, single
// write or block fill). A round-robin arbiter grants one channel at a time and
// the engine runs a single Avalon transaction with at most one read in flight.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ch_addr/len/writedata per-channel request payload (flattened, channel c at c*W)
//   ch_read, ch_write     per-channel request pulses (write wins if both)
//   ch_busy               channel has a pending or active request
//   ch_rvalid/readdata    per-word read return (shared data bus)
//   ch_rdy                completion pulse for the granted channel
//   avm_m1_*              Avalon-MM master
module dma_mc_engine #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned LW   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH*AW-1:0] ch_addr,
  input  logic [N_CH*LW-1:0] ch_len,
  input  logic [N_CH-1:0]    ch_read,
  input  logic [N_CH-1:0]    ch_write,
  input  logic [N_CH*DW-1:0] ch_writedata,
  output logic [N_CH-1:0]    ch_busy,
  output logic [N_CH-1:0]    ch_rvalid,
  output logic [DW-1:0]      ch_readdata,
  output logic [N_CH-1:0]    ch_rdy,
  output logic [AW-1:0]      avm_m1_address,
  output logic               avm_m1_read,
  output logic               avm_m1_write,
  output logic [DW-1:0]      avm_m1_writedata,
  input  logic               avm_m1_waitrequest,
  input  logic               avm_m1_readdatavalid,
  input  logic [DW-1:0]      avm_m1_readdata
);

  localparam int unsigned CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned STRIDE = DW / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_WR_REQ, S_DONE
  } state_e;

  state_e state_q, state_d;

  // Pending request slots, one per channel
  logic [N_CH-1:0] pend_q;
  logic [N_CH-1:0] slot_wr_q;
  logic [AW-1:0]   slot_addr_q [N_CH];
  logic [LW-1:0]   slot_len_q  [N_CH];
  logic [DW-1:0]   slot_data_q [N_CH];

  // Work registers for the granted transfer
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [CW-1:0] rr_q, rr_d;

  logic            grant_vld;
  logic [CW-1:0]   grant_ch;
  logic [31:0]     idx;
  logic [N_CH-1:0] ch_oh;

  assign ch_busy = pend_q;
  assign ch_oh   = N_CH'(1) << ch_q;

  // Request capture; a slot is freed only by its own DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      slot_wr_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        slot_addr_q[c] <= '0;
        slot_len_q[c]  <= '0;
        slot_data_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (state_q == S_DONE && ch_q == CW'(c)) begin
          pend_q[c] <= 1'b0;
        end else if (!pend_q[c] && (ch_read[c] || ch_write[c])) begin
          pend_q[c]      <= 1'b1;
          slot_wr_q[c]   <= ch_write[c];
          slot_addr_q[c] <= ch_addr[c*AW +: AW];
          slot_len_q[c]  <= ch_len[c*LW +: LW];
          slot_data_q[c] <= ch_writedata[c*DW +: DW];
        end
      end
    end
  end

  // Round-robin pick: first pending channel at or after rr_q
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (32'(rr_q) + 32'(i)) % 32'(N_CH);
      if (!grant_vld && pend_q[idx[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = idx[CW-1:0];
      end
    end
  end

  // State and work registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      ch_q       <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      ch_q       <= ch_d;
      rr_q       <= rr_d;
    end
  end

  // Next-state and work-register update
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    ch_d       = ch_q;
    rr_d       = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          ch_d       = grant_ch;
          cur_addr_d = slot_addr_q[grant_ch];
          rem_d      = (slot_len_q[grant_ch] == '0) ? LW'(1) : slot_len_q[grant_ch];
          data_d     = slot_data_q[grant_ch];
          state_d    = slot_wr_q[grant_ch] ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (!avm_m1_waitrequest) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (avm_m1_readdatavalid) begin
          rdata_d = avm_m1_readdata;
          state_d = S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        if (rem_q > LW'(1)) begin
          rem_d      = rem_q - LW'(1);
          cur_addr_d = cur_addr_q + AW'(STRIDE);
          state_d    = S_RD_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WR_REQ: begin
        // Fill words issue back-to-back while the slave accepts
        if (!avm_m1_waitrequest) begin
          if (rem_q > LW'(1)) begin
            rem_d      = rem_q - LW'(1);
            cur_addr_d = cur_addr_q + AW'(STRIDE);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        rr_d    = (ch_q == CW'(N_CH - 1)) ? '0 : ch_q + CW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    avm_m1_read      = 1'b0;
    avm_m1_write     = 1'b0;
    avm_m1_address   = '0;
    avm_m1_writedata = '0;
    ch_rvalid        = '0;
    ch_readdata      = '0;
    ch_rdy           = '0;
    unique case (state_q)
      S_RD_REQ: begin
        avm_m1_read    = 1'b1;
        avm_m1_address = cur_addr_q;
      end
      S_WR_REQ: begin
        avm_m1_write     = 1'b1;
        avm_m1_address   = cur_addr_q;
        avm_m1_writedata = data_q;
      end
      S_RD_OUT: begin
        ch_rvalid   = ch_oh;
        ch_readdata = rdata_q;
      end
      S_DONE:  ch_rdy = ch_oh;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_mc_engine.sv
// Testbench for dma_mc_engine: Avalon slave model with programmable wait and
// read latency, an event monitor, and per-scenario tasks that push expected
// events to a scoreboard queue and compare them against observed events.
module tb_dma_mc_engine;

  localparam int unsigned N_CH = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LW   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N_CH*AW-1:0] ch_addr = '0;
  logic [N_CH*LW-1:0] ch_len = '0;
  logic [N_CH-1:0]    ch_read = '0;
  logic [N_CH-1:0]    ch_write = '0;
  logic [N_CH*DW-1:0] ch_writedata = '0;
  logic [N_CH-1:0]    ch_busy;
  logic [N_CH-1:0]    ch_rvalid;
  logic [DW-1:0]      ch_readdata;
  logic [N_CH-1:0]    ch_rdy;
  logic [AW-1:0]      avm_m1_address;
  logic               avm_m1_read;
  logic               avm_m1_write;
  logic [DW-1:0]      avm_m1_writedata;
  logic               avm_wait = 1'b0;
  logic               avm_rdv = 1'b0;
  logic [DW-1:0]      avm_rdata = '0;

  dma_mc_engine #(.N_CH(N_CH), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ch_addr              (ch_addr),
    .ch_len               (ch_len),
    .ch_read              (ch_read),
    .ch_write             (ch_write),
    .ch_writedata         (ch_writedata),
    .ch_busy              (ch_busy),
    .ch_rvalid            (ch_rvalid),
    .ch_readdata          (ch_readdata),
    .ch_rdy               (ch_rdy),
    .avm_m1_address       (avm_m1_address),
    .avm_m1_read          (avm_m1_read),
    .avm_m1_write         (avm_m1_write),
    .avm_m1_writedata     (avm_m1_writedata),
    .avm_m1_waitrequest   (avm_wait),
    .avm_m1_readdatavalid (avm_rdv),
    .avm_m1_readdata      (avm_rdata)
  );

  always #5 clk = ~clk;

  // kind: 0 = Avalon read accepted, 1 = Avalon write accepted, 2 = rvalid, 3 = rdy
  typedef struct {
    int          kind;
    int          ch;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t act_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  cyc = 0;

  int          wait_cfg = 0;
  int          rdv_delay = 0;
  int          wcnt = 0;
  int          rd_cnt = 0;
  bit          rd_pend = 1'b0;
  logic [31:0] rd_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Avalon slave: reacts 2 time units after the edge to the settled outputs
  always @(posedge clk) begin
    #2;
    avm_rdv   = 1'b0;
    avm_rdata = '0;
    if (rd_pend) begin
      if (rd_cnt == 0) begin
        avm_rdv   = 1'b1;
        avm_rdata = mem_word(rd_addr);
        rd_pend   = 1'b0;
      end else begin
        rd_cnt--;
      end
    end
    avm_wait = 1'b0;
    if (avm_m1_read || avm_m1_write) begin
      if (wcnt < wait_cfg) begin
        avm_wait = 1'b1;
        wcnt++;
      end else begin
        wcnt = 0;
        if (avm_m1_read) begin
          rd_pend = 1'b1;
          rd_addr = avm_m1_address;
          rd_cnt  = rdv_delay;
        end
      end
    end
  end

  // Event monitor (records only; comparisons live in the test tasks)
  always @(negedge clk) begin
    if (rst_n) begin
      if ((avm_m1_read || avm_m1_write) && !avm_wait)
        act_q.push_back('{avm_m1_write ? 1 : 0, 0, avm_m1_address,
                          avm_m1_write ? avm_m1_writedata : 32'h0, cyc});
      for (int c = 0; c < N_CH; c++)
        if (ch_rvalid[c]) act_q.push_back('{2, c, 32'h0, ch_readdata, cyc});
      for (int c = 0; c < N_CH; c++)
        if (ch_rdy[c]) act_q.push_back('{3, c, 32'h0, 32'h0, cyc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_one(input int c, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [7:0] l, input logic [31:0] d, output int t0);
    t0 = cyc;
    ch_addr[c*AW +: AW]      = a;
    ch_len[c*LW +: LW]       = l;
    ch_writedata[c*DW +: DW] = d;
    ch_read[c]  = rd;
    ch_write[c] = wr;
    @(posedge clk); #1;
    ch_read[c]  = 1'b0;
    ch_write[c] = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ch_busy == '0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({avm_m1_read, avm_m1_write, avm_m1_address, avm_m1_writedata, ch_busy, ch_rvalid,
         ch_rdy, ch_readdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: read=%b write=%b addr=%h wdata=%h busy=%b rvalid=%b rdy=%b rdata=%h, expected all 0",
               avm_m1_read, avm_m1_write, avm_m1_address, avm_m1_writedata, ch_busy, ch_rvalid,
               ch_rdy, ch_readdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({avm_m1_read, avm_m1_write, ch_busy, ch_rvalid, ch_rdy} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: read=%b write=%b busy=%b rvalid=%b rdy=%b, expected all 0",
               avm_m1_read, avm_m1_write, ch_busy, ch_rvalid, ch_rdy);
    end
  endtask

  task automatic test_single_read();
    int t0; bit ok; ev_t e, a;
    exp_q.delete(); act_q.delete();
    drive_one(0, 1'b1, 1'b0, 32'h100, 8'd0, 32'h0, t0);
    exp_q.push_back('{0, 0, 32'h100, 32'h0, t0 + 2});
    exp_q.push_back('{2, 0, 32'h0, 32'hDEADBEEF, t0 + 4});
    exp_q.push_back('{3, 0, 32'h0, 32'h0, t0 + 5});
    n_tests++;
    if (ch_busy !== 2'b01) begin
      n_fail++;
      $display("FAIL single_read busy_rise: got %b, expected 01", ch_busy);
    end
    while (cyc < t0 + 6) begin @(posedge clk); #1; end
    n_tests++;
    if (ch_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL single_read busy_fall: got %b, expected 00", ch_busy);
    end
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_read timeout: busy=%b, expected 00", ch_busy); end
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_read count: got %0d events, expected %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL single_read missing: got none, expected kind=%0d ch=%0d addr=%h data=%h", e.kind, e.ch, e.addr, e.data);
      end else begin
        a = act_q.pop_front();
        if (a.kind !== e.kind || a.ch !== e.ch || a.addr !== e.addr || a.data !== e.data || (e.cyc >= 0 && a.cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL single_read event: got kind=%0d ch=%0d addr=%h data=%h cyc=%0d, expected kind=%0d ch=%0d addr=%h data=%h cyc=%0d",
                   a.kind, a.ch, a.addr, a.data, a.cyc, e.kind, e.ch, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_block_read();
    int t0; bit ok; ev_t e, a;
    exp_q.delete(); act_q.delete();
    wait_cfg = 2;
    drive_one(1, 1'b1, 1'b0, 32'h200, 8'd4, 32'h0, t0);
    // Each word: 2 wait cycles + accept, RD_WAIT, RD_OUT = 5 cycles
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{0, 0, 32'h200 + 32'(4 * i), 32'h0, t0 + 4 + 5 * i});
      exp_q.push_back('{2, 1, 32'h0, mem_word(32'h200 + 32'(4 * i)), t0 + 6 + 5 * i});
    end
    exp_q.push_back('{3, 1, 32'h0, 32'h0, t0 + 22});
    wait_idle(ok);
    wait_cfg = 0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL block_read timeout: busy=%b, expected 00", ch_busy); end
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL block_read count: got %0d events, expected %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL block_read missing: got none, expected kind=%0d ch=%0d addr=%h data=%h", e.kind, e.ch, e.addr, e.data);
      end else begin
        a = act_q.pop_front();
        if (a.kind !== e.kind || a.ch !== e.ch || a.addr !== e.addr || a.data !== e.data || (e.cyc >= 0 && a.cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL block_read event: got kind=%0d ch=%0d addr=%h data=%h cyc=%0d, expected kind=%0d ch=%0d addr=%h data=%h cyc=%0d",
                   a.kind, a.ch, a.addr, a.data, a.cyc, e.kind, e.ch, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int t0; bit ok; ev_t e, a;
    exp_q.delete(); act_q.delete();
    for (int r = 0; r < 2; r++) begin
      t0 = cyc;
      ch_addr = {32'h400, 32'h300};
      ch_len = {8'd2, 8'd1};
      ch_writedata = {32'h11111111, 32'h0};
      ch_read = 2'b01;
      ch_write = 2'b10;
      @(posedge clk); #1;
      ch_write = 2'b00;
      // ch0 is busy now: this request must be dropped
      ch_addr[0 +: AW] = 32'h999;
      ch_read = 2'b01;
      @(posedge clk); #1;
      ch_read = 2'b00;
      exp_q.push_back('{0, 0, 32'h300, 32'h0, t0 + 2});
      exp_q.push_back('{2, 0, 32'h0, mem_word(32'h300), t0 + 4});
      exp_q.push_back('{3, 0, 32'h0, 32'h0, t0 + 5});
      exp_q.push_back('{1, 0, 32'h400, 32'h11111111, t0 + 7});
      exp_q.push_back('{1, 0, 32'h404, 32'h11111111, t0 + 8});
      exp_q.push_back('{3, 1, 32'h0, 32'h0, t0 + 9});
      wait_idle(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL round_robin timeout: busy=%b, expected 00", ch_busy); end
    end
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL round_robin count: got %0d events, expected %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL round_robin missing: got none, expected kind=%0d ch=%0d addr=%h data=%h", e.kind, e.ch, e.addr, e.data);
      end else begin
        a = act_q.pop_front();
        if (a.kind !== e.kind || a.ch !== e.ch || a.addr !== e.addr || a.data !== e.data || (e.cyc >= 0 && a.cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL round_robin event: got kind=%0d ch=%0d addr=%h data=%h cyc=%0d, expected kind=%0d ch=%0d addr=%h data=%h cyc=%0d",
                   a.kind, a.ch, a.addr, a.data, a.cyc, e.kind, e.ch, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_fill_wrap();
    int t0; bit ok; ev_t e, a;
    logic [31:0] ad;
    exp_q.delete(); act_q.delete();
    drive_one(0, 1'b0, 1'b1, 32'hFFFFFFF8, 8'd4, 32'h0, t0);
    ad = 32'hFFFFFFF8;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{1, 0, ad, 32'h0, t0 + 2 + i});
      ad = ad + 32'd4;
    end
    exp_q.push_back('{3, 0, 32'h0, 32'h0, t0 + 6});
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL fill_wrap timeout: busy=%b, expected 00", ch_busy); end
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL fill_wrap count: got %0d events, expected %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL fill_wrap missing: got none, expected kind=%0d ch=%0d addr=%h data=%h", e.kind, e.ch, e.addr, e.data);
      end else begin
        a = act_q.pop_front();
        if (a.kind !== e.kind || a.ch !== e.ch || a.addr !== e.addr || a.data !== e.data || (e.cyc >= 0 && a.cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL fill_wrap event: got kind=%0d ch=%0d addr=%h data=%h cyc=%0d, expected kind=%0d ch=%0d addr=%h data=%h cyc=%0d",
                   a.kind, a.ch, a.addr, a.data, a.cyc, e.kind, e.ch, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_read_write_both();
    int t0; bit ok; ev_t e, a;
    exp_q.delete(); act_q.delete();
    drive_one(0, 1'b1, 1'b1, 32'h500, 8'd0, 32'hCAFEF00D, t0);
    exp_q.push_back('{1, 0, 32'h500, 32'hCAFEF00D, t0 + 2});
    exp_q.push_back('{3, 0, 32'h0, 32'h0, t0 + 3});
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rw_both timeout: busy=%b, expected 00", ch_busy); end
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rw_both count: got %0d events, expected %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL rw_both missing: got none, expected kind=%0d ch=%0d addr=%h data=%h", e.kind, e.ch, e.addr, e.data);
      end else begin
        a = act_q.pop_front();
        if (a.kind !== e.kind || a.ch !== e.ch || a.addr !== e.addr || a.data !== e.data || (e.cyc >= 0 && a.cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL rw_both event: got kind=%0d ch=%0d addr=%h data=%h cyc=%0d, expected kind=%0d ch=%0d addr=%h data=%h cyc=%0d",
                   a.kind, a.ch, a.addr, a.data, a.cyc, e.kind, e.ch, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int t0; bit ok; ev_t e, a;
    exp_q.delete(); act_q.delete();
    rdv_delay = 3;
    drive_one(0, 1'b1, 1'b0, 32'h600, 8'd4, 32'h0, t0);
    for (int i = 0; i < 20 && act_q.size() == 0; i++) begin @(negedge clk); #1; end
    n_tests++;
    if (act_q.size() == 0) begin n_fail++; $display("FAIL reset_mid first_read: got no read, expected one"); end
    @(posedge clk); #3;
    n_tests++;
    if (avm_m1_read !== 1'b0 || ch_busy !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid in_rd_wait: read=%b busy=%b, expected read=0 busy=01", avm_m1_read, ch_busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({avm_m1_read, avm_m1_write, avm_m1_address, avm_m1_writedata, ch_busy, ch_rvalid,
         ch_rdy, ch_readdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: read=%b write=%b addr=%h busy=%b rvalid=%b rdy=%b, expected all 0",
               avm_m1_read, avm_m1_write, avm_m1_address, ch_busy, ch_rvalid, ch_rdy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    act_q.delete();
    // The slave's late readdatavalid lands inside this window
    repeat (6) @(negedge clk);
    #1;
    rdv_delay = 0;
    n_tests++;
    if (act_q.size() != 0 || ch_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid late_rdv: got %0d events busy=%b, expected 0 events busy=00", act_q.size(), ch_busy);
    end
    act_q.delete();
    @(posedge clk); #1;
    drive_one(1, 1'b1, 1'b0, 32'h700, 8'd1, 32'h0, t0);
    exp_q.push_back('{0, 0, 32'h700, 32'h0, t0 + 2});
    exp_q.push_back('{2, 1, 32'h0, mem_word(32'h700), t0 + 4});
    exp_q.push_back('{3, 1, 32'h0, 32'h0, t0 + 5});
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL reset_mid timeout: busy=%b, expected 00", ch_busy); end
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_mid count: got %0d events, expected %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL reset_mid missing: got none, expected kind=%0d ch=%0d addr=%h data=%h", e.kind, e.ch, e.addr, e.data);
      end else begin
        a = act_q.pop_front();
        if (a.kind !== e.kind || a.ch !== e.ch || a.addr !== e.addr || a.data !== e.data || (e.cyc >= 0 && a.cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL reset_mid event: got kind=%0d ch=%0d addr=%h data=%h cyc=%0d, expected kind=%0d ch=%0d addr=%h data=%h cyc=%0d",
                   a.kind, a.ch, a.addr, a.data, a.cyc, e.kind, e.ch, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_block_read();
    test_round_robin();
    test_fill_wrap();
    test_read_write_both();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_mc_engine.md
# dma_mc_engine

Multi-channel Avalon-MM master DMA engine for the AI memory path: the parametrised successor to the single-client, single-word DMA.
- Up to N_CH client ports each post one request at a time: single-word read, block read of LEN words, single-word write, or block fill (memset-style write of one data word over LEN consecutive words).
- A round-robin arbiter grants one channel at a time; the engine runs one Avalon transaction at a time with at most one read outstanding.

## Interface
Parameters:
- N_CH, 2 — number of client channels (1..8)
- AW, 32 — address width
- DW, 32 — data width; byte stride per word = DW/8
- LW, 8 — width of per-channel length field (words)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ch_addr  in  N_CH*AW  per-channel start byte address, channel c at [c*AW +: AW]
- ch_len  in  N_CH*LW  per-channel word count; 0 treated as 1
- ch_read  in  N_CH  per-channel read request pulse
- ch_write  in  N_CH  per-channel write/fill request pulse
- ch_writedata  in  N_CH*DW  per-channel write/fill data
- ch_busy  out  N_CH  channel has a pending or active request
- ch_rvalid  out  N_CH  one-cycle pulse: ch_readdata holds a word for that channel
- ch_readdata  out  DW  shared read-data bus, valid only with a ch_rvalid bit
- ch_rdy  out  N_CH  one-cycle completion pulse for the granted channel
- avm_m1_address  out  AW  Avalon address
- avm_m1_read  out  1  Avalon read
- avm_m1_write  out  1  Avalon write
- avm_m1_writedata  out  DW  Avalon write data
- avm_m1_waitrequest  in  1  Avalon wait
- avm_m1_readdatavalid  in  1  Avalon read-data valid
- avm_m1_readdata  in  DW  Avalon read data

## Operation
- Request capture:
  - When ch_busy[c]=0 and ch_read[c] or ch_write[c] is high, latch addr, len, writedata and mode into channel c's pending slot; ch_busy[c] rises next cycle.
  - If both read and write are high, write wins.
  - Requests while ch_busy[c]=1 are dropped silently.
- Arbiter:
  - Active in IDLE only.
  - Grants the first pending channel at or after rr_ptr, modulo N_CH.
  - Loads the work registers: cur_addr, remaining = max(len,1), data, mode, ch id.
  - On DONE, rr_ptr = granted ch + 1 (mod N_CH).
- States:
  - IDLE: no pending → stay. Grant → RD_REQ (read) or WR_REQ (write/fill).
  - RD_REQ: avm_m1_read=1, avm_m1_address=cur_addr. Hold until waitrequest=0, then → RD_WAIT.
  - RD_WAIT: wait for readdatavalid; capture readdata → RD_OUT.
  - RD_OUT: ch_rvalid[ch]=1, ch_readdata=captured word. If remaining>1: remaining−1, cur_addr+DW/8, → RD_REQ. Else → DONE.
  - WR_REQ: avm_m1_write=1, address=cur_addr, writedata=data. On waitrequest=0: if remaining>1, remaining−1, cur_addr+DW/8, stay in WR_REQ; else → DONE.
  - DONE: ch_rdy[ch]=1; clear pending[ch] → IDLE.
- Address arithmetic: modulo 2^AW; wraps 0xFFFFFFFC→0x0 for AW=32, DW=32 with no error.
- Avalon and client outputs are decoded from registered state only. All are 0 outside the states that drive them; ch_readdata is 0 when no rvalid is asserted.

## Timing
- Reset (rst_n=0, asynchronous):
  - State → IDLE; all pending, ch_busy, rr_ptr, work registers → 0.
  - All outputs 0 immediately.
  - An in-flight transfer is abandoned with no rvalid and no rdy.
  - A readdatavalid arriving after reset release is ignored.
- Single-word read latency, with request at edge k, zero wait, and readdatavalid in the first RD_WAIT cycle:
  - ch_busy high cycle k+1 (IDLE grants)
  - avm_m1_read cycle k+2
  - RD_WAIT k+3
  - ch_rvalid k+4
  - ch_rdy k+5
  - ch_busy low k+6; a new request is accepted from k+6.
- Block read: 3 cycles per word at zero wait, plus 1 DONE cycle.
- Block fill: 1 cycle per word at zero wait, so avm_m1_write stays high back-to-back for LEN cycles.
- Waitrequest stretches RD_REQ/WR_REQ. Address and data stay stable while waitrequest=1.
- Channels requesting in the same cycle: lowest index at or after rr_ptr is served first; the others stay pending, each served after the previous DONE.

## Test plan
- Single read ch0, addr 0x100, len 0, readdata 0xDEADBEEF, no wait → read at k+2, ch_rvalid[0] with 0xDEADBEEF at k+4, ch_rdy[0] at k+5.
- Block read ch1, addr 0x200, len 4, waitrequest high 2 cycles on each word → addresses 0x200/204/208/20C in order, 4 rvalid[1] pulses with matching data, single rdy[1] after the last.
- Fill ch0, addr 0xFFFFFFF8, len 4, data 0x0 → writes to 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 on consecutive cycles, then rdy[0].
- ch0 and ch1 request in the same cycle, rr_ptr=0, then both re-request → order ch0, ch1, ch0, ch1; a re-request while busy is dropped (no extra rdy).
- read+write on ch0 in the same cycle → write performed, no avm_m1_read.
- rst_n low during RD_WAIT of a 4-word read → outputs 0 immediately, no rvalid or rdy; after release, a late readdatavalid is ignored and the engine accepts a new request.
